adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 24 ++
 rtl/ripple_adder.sv | 32 +++
 rtl/adder_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/adder_arbiter_pkg.sv
//==============================================================================
// Module   : adder_arbiter_pkg
// Purpose  : Shared FSM state encoding and id-width helper for adder_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package adder_arbiter_pkg;

   // Arbiter sequencing: accept a request, add, then hold the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ripple_adder.sv
//==============================================================================
// Module   : ripple_adder
// Purpose  : N-bit ripple-carry adder, a + b + cin -> {cout, s}.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ripple_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N:0] carry;

   assign carry[0] = cin;

   // One full-adder cell per bit, carry rippling upward.
   for (genvar i = 0; i < N; i++) begin : g_bit
      assign s[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[N];

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
//==============================================================================
// Module   : adder_arbiter
// Purpose  : Round-robin arbiter sharing one ripple_adder among R requesters.
//            Optional macro ADDER_ARBITER_SAT_EN saturates the sum on carry-out.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int N = 8,
   parameter int R = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [R-1:0]              req_valid,
   output logic [R-1:0]              req_ready,
   input  logic [R*N-1:0]            req_a,
   input  logic [R*N-1:0]            req_b,
   input  logic [R-1:0]              req_cin,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [N-1:0]              rsp_sum,
   output logic                      rsp_cout,
   output logic [id_width(R)-1:0]    rsp_id
);

   localparam int IW = id_width(R);

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   grant_id;
   logic            grant_found;
   logic            grant_fire;
   logic [N-1:0]    op_a;
   logic [N-1:0]    op_b;
   logic            op_cin;
   logic [N-1:0]    add_s;
   logic            add_cout;

   ripple_adder #(
      .N (N)
   ) u_adder (
      .a    (op_a),
      .b    (op_b),
      .cin  (op_cin),
      .s    (add_s),
      .cout (add_cout)
   );

   // Round-robin search: first valid requester at or after ptr, wrapping.
   always_comb begin
      logic [IW-1:0] idx;
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = '0;
      for (int k = 0; k < R; k++) begin
         idx = IW'((int'(ptr) + k) % R);
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = idx;
         end
      end
   end

   assign grant_fire = (state == IDLE) && grant_found;
   assign rsp_valid  = (state == RESP);

   // Accept strobe is one-hot on the winner, only while idle.
   always_comb begin
      req_ready = '0;
      if (grant_fire) begin
         req_ready = R'(1) << grant_id;
      end
   end

   // Next-state logic for the IDLE -> ADD -> RESP sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_found) state_nxt = ADD;
         ADD:     state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand capture on grant, result capture in ADD; result held through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_cin   <= 1'b0;
         rsp_id   <= '0;
         rsp_sum  <= '0;
         rsp_cout <= 1'b0;
      end else begin
         if (grant_fire) begin
            op_a   <= req_a[grant_id*N +: N];
            op_b   <= req_b[grant_id*N +: N];
            op_cin <= req_cin[grant_id];
            rsp_id <= grant_id;
            ptr    <= (grant_id == IW'(R - 1)) ? '0 : grant_id + 1'b1;
         end
         if (state == ADD) begin
`ifdef ADDER_ARBITER_SAT_EN
            rsp_sum  <= add_cout ? '1 : add_s;
`else
            rsp_sum  <= add_s;
`endif
            rsp_cout <= add_cout;
         end
      end
   end

endmodule

`default_nettype wire
